// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared response codes, FSM states and decode helper for the AXI4-Lite register file
package regfile_pkg;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_SLVERR = 2'b10
  } axi_resp_t;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // Number of byte-address bits below the register index.
  function automatic int byte_offs(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/axi_lite_regfile_if.sv
// rtl/axi_lite_regfile_if.sv - AXI4-Lite bus bundle with master and slave views
interface axi_lite_regfile_if #(
  parameter int DW = 32,
  parameter int AW = 6
);
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/regfile_bank.sv
// rtl/regfile_bank.sv - register storage, byte-lane merge and per-register write pulses
// Byte-lane merging is enabled by REGFILE_STRB_EN; otherwise every write replaces the full word.
module regfile_bank #(
  parameter int            DW        = 32,
  parameter int            NUM_REGS  = 16,
  parameter int            IW        = 4,
  parameter logic [DW-1:0] RESET_VAL = '0
) (
  input  logic                   i_clk,
  input  logic                   i_resetn,
  input  logic                   i_wr_en,
  input  logic [IW-1:0]          i_wr_idx,
  input  logic [DW-1:0]          i_wr_data,
  input  logic [DW/8-1:0]        i_wr_strb,
  output logic [NUM_REGS*DW-1:0] o_reg_q,
  output logic [NUM_REGS-1:0]    o_reg_wr_pulse
);

  logic [DW-1:0]       r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_pulse;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
      r_pulse <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_pulse[i] <= i_wr_en && (i_wr_idx == IW'(i));
        if (i_wr_en && (i_wr_idx == IW'(i))) begin
`ifdef REGFILE_STRB_EN
          for (int b = 0; b < DW / 8; b++) begin
            if (i_wr_strb[b]) r_regs[i][b*8 +: 8] <= i_wr_data[b*8 +: 8];
          end
`else
          r_regs[i] <= i_wr_data;
`endif
        end
      end
    end
  end

`ifndef REGFILE_STRB_EN
  logic w_unused_strb;
  assign w_unused_strb = ^i_wr_strb;
`endif

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
    assign o_reg_q[g*DW +: DW] = r_regs[g];
  end

  assign o_reg_wr_pulse = r_pulse;

endmodule

// File: rtl/axi_lite_regfile.sv
// rtl/axi_lite_regfile.sv - parametrised AXI4-Lite slave register file with independent read/write FSMs
// Optional byte-strobe writes via REGFILE_STRB_EN (handled in regfile_bank).
module axi_lite_regfile #(
  parameter int                              C_S_AXI_DATA_WIDTH = 32,
  parameter int                              C_S_AXI_ADDR_WIDTH = 6,
  parameter int                              NUM_REGS           = 16,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0]   RESET_VAL          = '0
) (
  input  logic                                    s00_axi_aclk,
  input  logic                                    s00_axi_aresetn,
  axi_lite_regfile_if.slave                       s00_axi,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]  reg_q,
  output logic [NUM_REGS-1:0]                     reg_wr_pulse
);
  import regfile_pkg::*;

  localparam int DW   = C_S_AXI_DATA_WIDTH;
  localparam int AW   = C_S_AXI_ADDR_WIDTH;
  localparam int SW   = DW / 8;
  localparam int OFFS = byte_offs(DW);
  localparam int IW   = AW - OFFS;

  wr_state_t     r_wstate;
  logic          r_awready, r_wready, r_aw_full, r_w_full, r_bvalid;
  logic [IW-1:0] r_aw_idx;
  logic [DW-1:0] r_w_data;
  logic [SW-1:0] r_w_strb;
  axi_resp_t     r_bresp;

  rd_state_t     r_rstate;
  logic          r_arready, r_rvalid;
  logic [DW-1:0] r_rdata;
  axi_resp_t     r_rresp;

  logic                   w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wr_in_range, w_ar_in_range;
  logic [IW-1:0]          w_wr_idx, w_ar_idx;
  logic [DW-1:0]          w_wr_data, w_rd_word;
  logic [SW-1:0]          w_wr_strb;
  logic [NUM_REGS*DW-1:0] w_reg_q;
  logic                   w_unused;

  assign w_aw_hs = s00_axi.awvalid & r_awready;
  assign w_w_hs  = s00_axi.wvalid & r_wready;
  assign w_ar_hs = s00_axi.arvalid & r_arready;

  // Commit bypasses the holders so the response lands one cycle after the later handshake.
  assign w_wr_idx      = r_aw_full ? r_aw_idx : s00_axi.awaddr[AW-1:OFFS];
  assign w_wr_data     = r_w_full ? r_w_data : s00_axi.wdata;
  assign w_wr_strb     = r_w_full ? r_w_strb : s00_axi.wstrb;
  assign w_wr_in_range = int'(w_wr_idx) < NUM_REGS;
  assign w_commit      = (r_wstate == W_IDLE) && (r_aw_full || w_aw_hs) && (r_w_full || w_w_hs);

  assign w_ar_idx      = s00_axi.araddr[AW-1:OFFS];
  assign w_ar_in_range = int'(w_ar_idx) < NUM_REGS;

  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_ar_idx == IW'(i)) w_rd_word = w_reg_q[i*DW +: DW];
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_aw_idx  <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= AXI_RESP_OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_commit) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_wr_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            r_wstate  <= W_RESP;
          end else begin
            r_awready <= !(r_aw_full || w_aw_hs);
            r_wready  <= !(r_w_full || w_w_hs);
            if (w_aw_hs) begin
              r_aw_full <= 1'b1;
              r_aw_idx  <= s00_axi.awaddr[AW-1:OFFS];
            end
            if (w_w_hs) begin
              r_w_full <= 1'b1;
              r_w_data <= s00_axi.wdata;
              r_w_strb <= s00_axi.wstrb;
            end
          end
        end
        W_RESP: begin
          if (s00_axi.bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= AXI_RESP_OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_ar_in_range ? w_rd_word : '0;
            r_rresp   <= w_ar_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            r_rstate  <= R_DATA;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s00_axi.rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
      endcase
    end
  end

  regfile_bank #(
    .DW       (DW),
    .NUM_REGS (NUM_REGS),
    .IW       (IW),
    .RESET_VAL(RESET_VAL)
  ) u_bank (
    .i_clk         (s00_axi_aclk),
    .i_resetn      (s00_axi_aresetn),
    .i_wr_en       (w_commit && w_wr_in_range),
    .i_wr_idx      (w_wr_idx),
    .i_wr_data     (w_wr_data),
    .i_wr_strb     (w_wr_strb),
    .o_reg_q       (w_reg_q),
    .o_reg_wr_pulse(reg_wr_pulse)
  );

  assign reg_q = w_reg_q;

  assign s00_axi.awready = r_awready;
  assign s00_axi.wready  = r_wready;
  assign s00_axi.bvalid  = r_bvalid;
  assign s00_axi.bresp   = r_bresp;
  assign s00_axi.arready = r_arready;
  assign s00_axi.rvalid  = r_rvalid;
  assign s00_axi.rdata   = r_rdata;
  assign s00_axi.rresp   = r_rresp;

  assign w_unused = ^{s00_axi.awprot, s00_axi.arprot,
                      s00_axi.awaddr[OFFS-1:0], s00_axi.araddr[OFFS-1:0]};

endmodule

// File: tb/tb_axi_lite_regfile.sv
// tb/tb_axi_lite_regfile.sv - randomized self-checking bench for axi_lite_regfile against a register-array model
module tb_axi_lite_regfile;
  localparam int          DW = 32;
  localparam int          AW = 6;
  localparam int          NR = 12;
  localparam logic [31:0] RV = 32'h5A5A_0001;
`ifdef REGFILE_STRB_EN
  localparam bit STRB_EN = 1'b1;
`else
  localparam bit STRB_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [NR*DW-1:0] reg_q;
  logic [NR-1:0]    reg_wr_pulse;
  int               n_cmp = 0;
  int               n_err = 0;
  logic [31:0]      model [NR];

  axi_lite_regfile_if #(.DW(DW), .AW(AW)) bus ();

  axi_lite_regfile #(
    .C_S_AXI_DATA_WIDTH(DW),
    .C_S_AXI_ADDR_WIDTH(AW),
    .NUM_REGS          (NR),
    .RESET_VAL         (RV)
  ) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_aresetn(resetn),
    .s00_axi        (bus.slave),
    .reg_q          (reg_q),
    .reg_wr_pulse   (reg_wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit in_range(input logic [5:0] a);
    return int'(a[5:2]) < NR;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[b*8 +: 8] = (strb[b] || !STRB_EN) ? data[b*8 +: 8] : old_v[b*8 +: 8];
    return r;
  endfunction

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++) check(tag, 64'(reg_q[i*DW +: DW]), 64'(model[i]));
  endtask

  task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    int          cyc = 0;
    bit          aw_done = 0, w_done = 0;
    logic [NR-1:0] exp_pulse;
    logic [1:0]  exp_resp;
    exp_pulse = in_range(addr) ? (NR'(1) << addr[5:2]) : '0;
    exp_resp  = in_range(addr) ? 2'b00 : 2'b10;
    while (!(aw_done && w_done) && cyc < 50) begin
      bus.awaddr  = addr;
      bus.wdata   = data;
      bus.wstrb   = strb;
      bus.awvalid = !aw_done && cyc >= aw_dly;
      bus.wvalid  = !w_done && cyc >= w_dly;
      if (w_done && !aw_done) check("wready_held_full", 64'(bus.wready), 64'(0));
      if (aw_done && !w_done) check("awready_held_full", 64'(bus.awready), 64'(0));
      if (bus.awvalid && bus.awready) aw_done = 1;
      if (bus.wvalid && bus.wready) w_done = 1;
      @(negedge clk);
      cyc++;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    if (!(aw_done && w_done)) begin
      check("wr_handshake_timeout", 64'(0), 64'(1));
      return;
    end
    check("bvalid_latency", 64'(bus.bvalid), 64'(1));
    check("bresp", 64'(bus.bresp), 64'(exp_resp));
    check("wr_pulse", 64'(reg_wr_pulse), 64'(exp_pulse));
    if (in_range(addr)) model[addr[5:2]] = merge(model[addr[5:2]], data, strb);
    check_regs("reg_q_after_wr");
    for (int i = 0; i < b_dly; i++) begin
      @(negedge clk);
      check("bvalid_hold", 64'(bus.bvalid), 64'(1));
      check("bresp_hold", 64'(bus.bresp), 64'(exp_resp));
      check("awready_in_resp", 64'(bus.awready), 64'(0));
      check("wready_in_resp", 64'(bus.wready), 64'(0));
    end
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check("bvalid_clear", 64'(bus.bvalid), 64'(0));
    check("wr_pulse_clear", 64'(reg_wr_pulse), 64'(0));
  endtask

  task automatic do_read(input logic [5:0] addr, input int r_dly);
    int          cnt = 0;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    while (!bus.arready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (!bus.arready) begin
      bus.arvalid = 1'b0;
      check("rd_handshake_timeout", 64'(0), 64'(1));
      return;
    end
    // The model only changes at negedges, so this snapshot is the pre-edge register state.
    @(posedge clk);
    exp_d = 32'h0;
    exp_r = 2'b10;
    if (in_range(addr)) begin
      exp_d = model[addr[5:2]];
      exp_r = 2'b00;
    end
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("rvalid_latency", 64'(bus.rvalid), 64'(1));
    check("rdata", 64'(bus.rdata), 64'(exp_d));
    check("rresp", 64'(bus.rresp), 64'(exp_r));
    for (int i = 0; i < r_dly; i++) begin
      @(negedge clk);
      check("rvalid_hold", 64'(bus.rvalid), 64'(1));
      check("rdata_hold", 64'(bus.rdata), 64'(exp_d));
      check("arready_busy", 64'(bus.arready), 64'(0));
    end
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    check("rvalid_clear", 64'(bus.rvalid), 64'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 0;
    bus.wdata = '0;  bus.wstrb = '0;  bus.wvalid = 0;  bus.bready = 0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 0; bus.rready = 0;
    for (int i = 0; i < NR; i++) model[i] = RV;

    repeat (3) @(negedge clk);
    check("rst_awready", 64'(bus.awready), 64'(0));
    check("rst_wready", 64'(bus.wready), 64'(0));
    check("rst_arready", 64'(bus.arready), 64'(0));
    check("rst_bvalid", 64'(bus.bvalid), 64'(0));
    check("rst_rvalid", 64'(bus.rvalid), 64'(0));
    check("rst_bresp", 64'(bus.bresp), 64'(0));
    check("rst_rresp", 64'(bus.rresp), 64'(0));
    check("rst_rdata", 64'(bus.rdata), 64'(0));
    check("rst_pulse", 64'(reg_wr_pulse), 64'(0));
    check_regs("rst_reg_q");
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) do_write(6'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_read(6'(i * 4), 1);
    check("basic_reg3", 64'(reg_q[3*DW +: DW]), 64'd4);

    do_write(6'(NR * 4), 32'h0000_DEAD, 4'hF, 0, 0, 0);
    do_read(6'(NR * 4), 0);
    do_read(6'h3F, 0);

    do_write(6'h00, 32'h1122_3344, 4'hF, 0, 0, 0);
    do_write(6'h00, 32'h0000_00FF, 4'h1, 0, 0, 0);
    check("strb_reg0", 64'(reg_q[31:0]), STRB_EN ? 64'h1122_33FF : 64'h0000_00FF);
    do_read(6'h00, 0);

    do_write(6'h24, 32'hA0A0_0009, 4'hF, 3, 0, 0);
    do_write(6'h28, 32'hB0B0_000A, 4'hF, 0, 2, 0);

    fork
      do_write(6'h14, 32'h1357_9BDF, 4'hF, 0, 0, 5);
      begin
        repeat (2) @(negedge clk);
        do_read(6'h18, 0);
      end
    join

    do_write(6'h08, 32'h7777_0003, 4'hF, 0, 0, 0);
    fork
      do_write(6'h08, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
      do_read(6'h08, 0);
    join

    bus.awaddr = 6'h0C;
    bus.awvalid = 1'b1;
    cnt = 0;
    while (!bus.awready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("rst_mid_aw_accept", 64'(bus.awready), 64'(1));
    @(negedge clk);
    bus.wdata = 32'h1234_5678;
    bus.wstrb = 4'hF;
    bus.wvalid = 1'b1;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = RV;
    check("rst_mid_awready", 64'(bus.awready), 64'(0));
    check("rst_mid_pulse", 64'(reg_wr_pulse), 64'(0));
    check_regs("rst_mid_reg_q");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_no_bvalid", 64'(bus.bvalid), 64'(0));
    end
    do_write(6'h0C, 32'h0BAD_BEEF, 4'hF, 0, 0, 0);
    do_read(6'h0C, 0);

    for (int k = 0; k < 40; k++) begin
      automatic logic [5:0]  wa = 6'($urandom_range(0, 63));
      automatic logic [5:0]  ra = 6'($urandom_range(0, 63));
      automatic logic [31:0] wd = $urandom;
      automatic logic [3:0]  ws = 4'($urandom_range(0, 15));
      automatic int          ad = $urandom_range(0, 3);
      automatic int          wdl = $urandom_range(0, 3);
      automatic int          bd = $urandom_range(0, 2);
      automatic int          rs = $urandom_range(0, 4);
      automatic int          rd = $urandom_range(0, 2);
      fork
        do_write(wa, wd, ws, ad, wdl, bd);
        begin
          repeat (rs) @(negedge clk);
          do_read(ra, rd);
        end
      join
    end
    for (int i = 0; i < NR; i++) do_read(6'(i * 4), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
